// File: rtl/triangle_setup.sv
// rtl/triangle_setup.sv - triangle edge/area/bbox setup with fixed 10-cycle latency; optional macro BACKFACE_CULL_EN
module triangle_setup #(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in_n,
    input  logic                                     start,
    input  logic signed [2:0][3:0][COORD_WIDTH-1:0]  projected_verts,
    output logic signed [2:0][COORD_WIDTH/2:0]       edge_a,
    output logic signed [2:0][COORD_WIDTH/2:0]       edge_b,
    output logic signed [2:0][COORD_WIDTH+1:0]       edge_c,
    output logic signed [COORD_WIDTH+2:0]            area,
    output logic [$clog2(FB_WIDTH)-1:0]              bbox_min_x,
    output logic [$clog2(FB_WIDTH)-1:0]              bbox_max_x,
    output logic [$clog2(FB_HEIGHT)-1:0]             bbox_min_y,
    output logic [$clog2(FB_HEIGHT)-1:0]             bbox_max_y,
    output logic signed [2:0][COORD_WIDTH-1:0]       attr_z,
    output logic signed [2:0][COORD_WIDTH-1:0]       attr_inv_w,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     valid,
    output logic [1:0]                               status
);

    localparam int H   = COORD_WIDTH / 2;
    localparam int CW2 = COORD_WIDTH + 2;
    localparam int AW  = COORD_WIDTH + 3;
    localparam int XW  = $clog2(FB_WIDTH);
    localparam int YW  = $clog2(FB_HEIGHT);
    localparam logic signed [H-1:0] X_MAX = H'(FB_WIDTH - 1);
    localparam logic signed [H-1:0] Y_MAX = H'(FB_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_AREA,
        S_CHECK,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0][3:0][COORD_WIDTH-1:0] r_verts;
    logic [2:0]                       r_mul_cnt;
    logic signed [H-1:0]              r_xi [3];
    logic signed [H-1:0]              r_yi [3];
    logic signed [2*H-1:0]            r_prod [6];
    logic signed [H-1:0]              r_min_x, r_max_x, r_min_y, r_max_y;
    logic [2:0][H:0]                  r_edge_a, r_edge_b;
    logic [2:0][CW2-1:0]              r_edge_c;
    logic signed [AW-1:0]             r_area;
    logic [XW-1:0]                    r_bbox_min_x, r_bbox_max_x;
    logic [YW-1:0]                    r_bbox_min_y, r_bbox_max_y;
    logic [2:0][COORD_WIDTH-1:0]      r_attr_z, r_attr_w;
    logic [1:0]                       r_status;

    logic signed [H-1:0]   w_xi [3];
    logic signed [H-1:0]   w_yi [3];
    logic signed [H:0]     w_a [3];
    logic signed [H:0]     w_b [3];
    logic signed [H-1:0]   w_min_x, w_max_x, w_min_y, w_max_y;
    logic signed [H-1:0]   w_ma, w_mb;
    logic signed [2*H-1:0] w_prod;
    logic signed [CW2-1:0] w_c [3];
    logic signed [AW-1:0]  w_area;
    logic                  w_disjoint;
    logic [1:0]            w_status;
    logic                  w_unused_frac;

    // Fractional vertex bits only matter for the floor, which the slice already performs.
    assign w_unused_frac = ^{r_verts[0][0][H-1:0], r_verts[0][1][H-1:0],
                             r_verts[1][0][H-1:0], r_verts[1][1][H-1:0],
                             r_verts[2][0][H-1:0], r_verts[2][1][H-1:0]};

    function automatic logic [XW-1:0] clamp_x(input logic signed [H-1:0] v);
        if (v[H-1])         return '0;
        else if (v > X_MAX) return XW'(FB_WIDTH - 1);
        else                return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic signed [H-1:0] v);
        if (v[H-1])         return '0;
        else if (v > Y_MAX) return YW'(FB_HEIGHT - 1);
        else                return v[YW-1:0];
    endfunction

    // Integer pixel coordinates, edge A/B coefficients and raw bounding box from the captured vertices.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_xi[i] = $signed(r_verts[i][0][COORD_WIDTH-1:H]);
            w_yi[i] = $signed(r_verts[i][1][COORD_WIDTH-1:H]);
        end
        for (int i = 0; i < 3; i++) begin
            w_a[i] = (H+1)'(w_yi[i]) - (H+1)'(w_yi[(i+1)%3]);
            w_b[i] = (H+1)'(w_xi[(i+1)%3]) - (H+1)'(w_xi[i]);
        end
        w_min_x = w_xi[0];
        w_max_x = w_xi[0];
        w_min_y = w_yi[0];
        w_max_y = w_yi[0];
        for (int i = 1; i < 3; i++) begin
            if (w_xi[i] < w_min_x) w_min_x = w_xi[i];
            if (w_xi[i] > w_max_x) w_max_x = w_xi[i];
            if (w_yi[i] < w_min_y) w_min_y = w_yi[i];
            if (w_yi[i] > w_max_y) w_max_y = w_yi[i];
        end
    end

    // Shared multiplier: even steps form x_i*y_j, odd steps x_j*y_i for edge i = step/2.
    always_comb begin
        w_ma = r_xi[0];
        w_mb = r_yi[1];
        case (r_mul_cnt)
            3'd0: begin w_ma = r_xi[0]; w_mb = r_yi[1]; end
            3'd1: begin w_ma = r_xi[1]; w_mb = r_yi[0]; end
            3'd2: begin w_ma = r_xi[1]; w_mb = r_yi[2]; end
            3'd3: begin w_ma = r_xi[2]; w_mb = r_yi[1]; end
            3'd4: begin w_ma = r_xi[2]; w_mb = r_yi[0]; end
            3'd5: begin w_ma = r_xi[0]; w_mb = r_yi[2]; end
            default: begin w_ma = r_xi[0]; w_mb = r_yi[1]; end
        endcase
        w_prod = w_ma * w_mb;
    end

    // Edge constants, area sum and the prioritised status classification.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_c[i] = CW2'(r_prod[2*i]) - CW2'(r_prod[2*i+1]);
        end
        w_area = AW'(w_c[0]) + AW'(w_c[1]) + AW'(w_c[2]);
        w_disjoint = r_max_x[H-1] || (r_min_x > X_MAX) || r_max_y[H-1] || (r_min_y > Y_MAX);
        w_status = 2'b00;
        if (r_area == '0) begin
            w_status = 2'b10;
`ifdef BACKFACE_CULL_EN
        end else if (r_area[AW-1]) begin
            w_status = 2'b01;
`endif
        end else if (w_disjoint) begin
            w_status = 2'b11;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LOAD;
            end
            S_LOAD:  w_next = S_MUL;
            S_MUL:   if (r_mul_cnt == 3'd5) w_next = S_AREA;
            S_AREA:  w_next = S_CHECK;
            S_CHECK: w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                valid  = (r_status == 2'b00);
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture, load, multiply sequence, area, then classification (and un-culled flip).
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_verts      <= '0;
            r_mul_cnt    <= '0;
            r_min_x      <= '0;
            r_max_x      <= '0;
            r_min_y      <= '0;
            r_max_y      <= '0;
            r_edge_a     <= '0;
            r_edge_b     <= '0;
            r_edge_c     <= '0;
            r_area       <= '0;
            r_bbox_min_x <= '0;
            r_bbox_max_x <= '0;
            r_bbox_min_y <= '0;
            r_bbox_max_y <= '0;
            r_attr_z     <= '0;
            r_attr_w     <= '0;
            r_status     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_xi[i] <= '0;
                r_yi[i] <= '0;
            end
            for (int i = 0; i < 6; i++) r_prod[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_verts <= projected_verts;
                end
                S_LOAD: begin
                    r_mul_cnt    <= '0;
                    r_min_x      <= w_min_x;
                    r_max_x      <= w_max_x;
                    r_min_y      <= w_min_y;
                    r_max_y      <= w_max_y;
                    r_bbox_min_x <= clamp_x(w_min_x);
                    r_bbox_max_x <= clamp_x(w_max_x);
                    r_bbox_min_y <= clamp_y(w_min_y);
                    r_bbox_max_y <= clamp_y(w_max_y);
                    for (int i = 0; i < 3; i++) begin
                        r_xi[i]     <= w_xi[i];
                        r_yi[i]     <= w_yi[i];
                        r_edge_a[i] <= w_a[i];
                        r_edge_b[i] <= w_b[i];
                        r_attr_z[i] <= r_verts[i][2];
                        r_attr_w[i] <= r_verts[i][3];
                    end
                end
                S_MUL: begin
                    r_prod[r_mul_cnt] <= w_prod;
                    r_mul_cnt         <= r_mul_cnt + 3'd1;
                end
                S_AREA: begin
                    for (int i = 0; i < 3; i++) r_edge_c[i] <= w_c[i];
                    r_area <= w_area;
                end
                S_CHECK: begin
                    r_status <= w_status;
`ifndef BACKFACE_CULL_EN
                    // Back-facing triangles are rewound so the rasteriser always sees positive area.
                    if (r_area[AW-1]) begin
                        r_area <= -r_area;
                        for (int i = 0; i < 3; i++) begin
                            r_edge_a[i] <= -r_edge_a[i];
                            r_edge_b[i] <= -r_edge_b[i];
                            r_edge_c[i] <= -r_edge_c[i];
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign edge_a     = r_edge_a;
    assign edge_b     = r_edge_b;
    assign edge_c     = r_edge_c;
    assign area       = r_area;
    assign bbox_min_x = r_bbox_min_x;
    assign bbox_max_x = r_bbox_max_x;
    assign bbox_min_y = r_bbox_min_y;
    assign bbox_max_y = r_bbox_max_y;
    assign attr_z     = r_attr_z;
    assign attr_inv_w = r_attr_w;
    assign status     = r_status;

endmodule

// File: tb/tb_triangle_setup.sv
// tb/tb_triangle_setup.sv - scoreboard bench for triangle_setup
module tb_triangle_setup;

    localparam int CW = 32;

    logic clk_in   = 1'b0;
    logic rst_in_n = 1'b0;
    logic start    = 1'b0;
    logic signed [2:0][3:0][CW-1:0] projected_verts = '0;
    logic signed [2:0][CW/2:0]      edge_a, edge_b;
    logic signed [2:0][CW+1:0]      edge_c;
    logic signed [CW+2:0]           area;
    logic [8:0]                     bbox_min_x, bbox_max_x;
    logic [7:0]                     bbox_min_y, bbox_max_y;
    logic signed [2:0][CW-1:0]      attr_z, attr_inv_w;
    logic                           busy, done, valid;
    logic [1:0]                     status;

    triangle_setup #(.COORD_WIDTH(CW), .FB_WIDTH(320), .FB_HEIGHT(180)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .start(start), .projected_verts(projected_verts),
        .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c), .area(area),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x), .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .attr_z(attr_z), .attr_inv_w(attr_inv_w), .busy(busy), .done(done), .valid(valid), .status(status)
    );

    typedef struct {
        longint a[3];
        longint b[3];
        longint c[3];
        longint ar;
        int     st;
        int     mnx, mxx, mny, mxy;
        longint z[3];
        longint w[3];
        longint due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   tag = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic int qv(input int v);
        return v * 65536;
    endfunction

    function automatic exp_t mk(input longint a0, a1, a2, b0, b1, b2, c0, c1, c2, ar,
                                input int st, mnx, mxx, mny, mxy);
        exp_t e;
        e.a[0] = a0; e.a[1] = a1; e.a[2] = a2;
        e.b[0] = b0; e.b[1] = b1; e.b[2] = b2;
        e.c[0] = c0; e.c[1] = c1; e.c[2] = c2;
        e.ar = ar; e.st = st;
        e.mnx = mnx; e.mxx = mxx; e.mny = mny; e.mxy = mxy;
        for (int i = 0; i < 3; i++) begin e.z[i] = 0; e.w[i] = 0; end
        e.due = 0;
        return e;
    endfunction

    // Drives one start pulse; pushes the expectation only when the start should be accepted.
    task automatic run_tri(input int x0, y0, x1, y1, x2, y2, input exp_t e_in, input bit expect_acc);
        exp_t e;
        int xs[3];
        int ys[3];
        e = e_in;
        xs = '{x0, x1, x2};
        ys = '{y0, y1, y2};
        tag++;
        for (int i = 0; i < 3; i++) begin
            projected_verts[i][0] = xs[i];
            projected_verts[i][1] = ys[i];
            projected_verts[i][2] = tag * 256 + i;
            projected_verts[i][3] = -(tag * 256 + i + 7);
            e.z[i] = tag * 256 + i;
            e.w[i] = -(tag * 256 + i + 7);
        end
        e.due = cyc + 10;
        if (expect_acc) q.push_back(e);
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk_in);
            n++;
        end
        #1;
        if (n >= 40) begin
            n_tot++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        chk("busy_idle", busy, 0);
    endtask

    // Monitor: every done pops one expectation; valid must stay low outside done.
    always @(negedge clk_in) begin
        if (rst_in_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    m_e = q.pop_front();
                    chk("latency", cyc, m_e.due);
                    chk("status", status, m_e.st);
                    chk("valid", valid, (m_e.st == 0) ? 1 : 0);
                    chk("area", area, m_e.ar);
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("edge_a%0d", i), $signed(edge_a[i]), m_e.a[i]);
                        chk($sformatf("edge_b%0d", i), $signed(edge_b[i]), m_e.b[i]);
                        chk($sformatf("edge_c%0d", i), $signed(edge_c[i]), m_e.c[i]);
                        chk($sformatf("attr_z%0d", i), $signed(attr_z[i]), m_e.z[i]);
                        chk($sformatf("attr_inv_w%0d", i), $signed(attr_inv_w[i]), m_e.w[i]);
                    end
                    chk("bbox_min_x", bbox_min_x, m_e.mnx);
                    chk("bbox_max_x", bbox_max_x, m_e.mxx);
                    chk("bbox_min_y", bbox_min_y, m_e.mny);
                    chk("bbox_max_y", bbox_max_y, m_e.mxy);
                end
            end else begin
                chk("valid_outside_done", valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t t1, t2, t3, t4, t5;
        t1 = mk(0, -10, 10, 10, -10, 0, -100, 300, -100, 100, 0, 10, 20, 10, 20);
`ifdef BACKFACE_CULL_EN
        t2 = mk(-10, 10, 0, 0, 10, -10, 100, -300, 100, -100, 1, 10, 20, 10, 20);
`else
        t2 = mk(10, -10, 0, 0, -10, 10, -100, 300, -100, 100, 0, 10, 20, 10, 20);
`endif
        t3 = mk(-5, -5, 10, 5, 5, -10, 0, 0, 0, 0, 2, 0, 10, 0, 10);
        t4 = mk(0, -10, 10, 10, -10, 0, 500, -900, 500, 100, 3, 0, 0, 0, 0);
        t5 = mk(-5, -300, 305, 405, -400, -5, 2000, 120000, 1500, 123500, 0, 0, 319, 0, 179);

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_status", status, 0);
        chk("rst_area", area, 0);
        chk("rst_edge_c1", $signed(edge_c[1]), 0);
        chk("rst_bbox_max_x", bbox_max_x, 0);
        chk("rst_attr_inv_w2", $signed(attr_inv_w[2]), 0);

        // Start on the first edge after reset release.
        rst_in_n = 1'b1;
        run_tri(qv(10), qv(10), qv(20), qv(10), qv(10), qv(20), t1, 1'b1);
        drain();

        // Reversed winding.
        run_tri(qv(10), qv(10), qv(10), qv(20), qv(20), qv(10), t2, 1'b1);
        drain();

        // Collinear.
        run_tri(qv(0), qv(0), qv(5), qv(5), qv(10), qv(10), t3, 1'b1);
        drain();

        // Offscreen, then back-to-back start in the cycle after done (includes a fractional negative x).
        run_tri(qv(-50), qv(-50), qv(-40), qv(-50), qv(-50), qv(-40), t4, 1'b1);
        repeat (10) @(posedge clk_in);
        #1;
        run_tri(qv(-5) + 32768, qv(-5), qv(400), qv(0), qv(0), qv(300), t5, 1'b1);
        drain();

        // Second start during MUL must be ignored.
        run_tri(qv(10), qv(10), qv(20), qv(10), qv(10), qv(20), t1, 1'b1);
        repeat (3) @(posedge clk_in);
        #1;
        run_tri(qv(-50), qv(-50), qv(-40), qv(-50), qv(-50), qv(-40), t4, 1'b0);
        drain();

        // Reset during AREA: outputs cleared, no done, then a normal triangle.
        run_tri(qv(0), qv(0), qv(5), qv(5), qv(10), qv(10), t3, 1'b0);
        repeat (7) @(posedge clk_in);
        #1;
        rst_in_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_status", status, 0);
        chk("abort_area", area, 0);
        chk("abort_edge_a1", $signed(edge_a[1]), 0);
        chk("abort_edge_b0", $signed(edge_b[0]), 0);
        chk("abort_bbox_max_x", bbox_max_x, 0);
        chk("abort_attr_z0", $signed(attr_z[0]), 0);
        @(posedge clk_in);
        #1;
        rst_in_n = 1'b1;
        run_tri(qv(10), qv(10), qv(20), qv(10), qv(10), qv(20), t1, 1'b1);
        drain();
        repeat (15) @(posedge clk_in);
        #1;
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/triangle_setup.md
TRIANGLE_SETUP -- requirements
Module: triangle_setup

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 32, the Q(COORD_WIDTH/2).(COORD_WIDTH/2) vertex word width.
REQ-002 SHALL have parameter FB_WIDTH, default 320, the framebuffer width in pixels.
REQ-003 SHALL have parameter FB_HEIGHT, default 180, the framebuffer height in pixels.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_in_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to accept a triangle.
REQ-007 SHALL have port projected_verts  input  signed [2:0][3:0][COORD_WIDTH-1:0]  per vertex {inv_w, z, y, x}, fixed point.
REQ-008 SHALL have ports edge_a, edge_b  output  signed [2:0][COORD_WIDTH/2:0]  edge-function x and y coefficients.
REQ-009 SHALL have port edge_c  output  signed [2:0][COORD_WIDTH+1:0]  edge-function constant.
REQ-010 SHALL have port area  output  signed [COORD_WIDTH+2:0]  twice the signed triangle area.
REQ-011 SHALL have ports bbox_min_x, bbox_max_x  output  [$clog2(FB_WIDTH)-1:0]  clamped pixel x bounds.
REQ-012 SHALL have ports bbox_min_y, bbox_max_y  output  [$clog2(FB_HEIGHT)-1:0]  clamped pixel y bounds.
REQ-013 SHALL have ports attr_z, attr_inv_w  output  signed [2:0][COORD_WIDTH-1:0]  registered copies of per-vertex z and inv_w.
REQ-014 SHALL have ports busy, done, valid  output  1 each, and status  output  2  (00 ok, 01 backface, 10 degenerate, 11 offscreen).

Function
REQ-015 SHALL accept start only in IDLE, capturing projected_verts that cycle; start while busy SHALL be ignored.
REQ-016 SHALL use states IDLE -> LOAD -> MUL (6 cycles) -> AREA -> CHECK -> DONE -> IDLE, with busy high in every state except IDLE.
REQ-017 SHALL form integer pixel coordinates xi, yi = bits [COORD_WIDTH-1:COORD_WIDTH/2] of x and y (floor, signed) in LOAD.
REQ-018 SHALL, in LOAD, compute edge i (j = (i+1) mod 3): A_i = y_i - y_j and B_i = x_j - x_i, sign-extended.
REQ-019 SHALL compute the 6 products x_i*y_j and x_j*y_i through one shared signed multiplier, one product per MUL cycle.
REQ-020 SHALL, in AREA, set C_i = x_i*y_j - x_j*y_i and area = C_0 + C_1 + C_2, with no truncation.
REQ-021 SHALL, in CHECK, select status by priority: area==0 -> 10; area<0 -> 01 (per REQ-031); bbox disjoint from framebuffer -> 11; else 00.
REQ-022 SHALL compute the bbox as min/max of xi, yi clamped to [0, FB_WIDTH-1] and [0, FB_HEIGHT-1].
REQ-023 SHALL treat the bbox as disjoint when max x < 0, min x > FB_WIDTH-1, max y < 0, or min y > FB_HEIGHT-1.
REQ-024 SHALL, in DONE, pulse done for exactly 1 cycle, with valid = (status==00) in that same cycle and low at all other times.
REQ-025 SHALL have a fixed latency: done is asserted exactly 10 cycles after the cycle in which start is accepted, for every outcome.
REQ-026 SHALL hold all result outputs stable from done until the next accepted start.
REQ-027 SHALL allow a new start to be accepted in the cycle after done.

Reset
REQ-028 SHALL, on rst_in_n low, immediately return to IDLE and clear busy, done, valid, status, and all result and attribute outputs to 0, including mid-operation.
REQ-029 SHALL NOT emit done for a triangle aborted by reset.
REQ-030 SHALL accept start on the first clk_in edge after rst_in_n deasserts.

Configuration
REQ-031 SHALL support macro BACKFACE_CULL_EN:
  - Defined: area<0 gives status 01 with valid low.
  - Undefined: area<0 is accepted; edge_a, edge_b, edge_c and area are output negated; valid follows the remaining checks.

Verification
REQ-032 SHALL pass: verts (10,10),(20,10),(10,20) in Q16.16 (x=0x000A0000) -> done at +10 cycles, valid=1, status=00, area=100, A0=0, B0=10, C0=-100, C1=300, bbox 10..20 x 10..20.
REQ-033 SHALL pass: verts (10,10),(10,20),(20,10) -> area=-100; with BACKFACE_CULL_EN, status=01, valid=0; without, valid=1, area=100, C1=300.
REQ-034 SHALL pass: collinear verts (0,0),(5,5),(10,10) -> status=10, valid=0, done at +10 cycles.
REQ-035 SHALL pass: verts (-50,-50),(-40,-50),(-50,-40) -> status=11, valid=0; verts (-5,-5),(400,0),(0,300) -> status=00, bbox 0..319 x 0..179.
REQ-036 SHALL pass: start asserted again during MUL -> ignored, single done; rst_in_n pulsed low in AREA -> outputs 0, no done, next start completes normally.
